// File: rtl/ham_pkg.sv
// ham_pkg: shared Hamming(7,4) types, serializer states and the codeword encoder.
package ham_pkg;
    localparam int HAM_CODE_W = 7;
    typedef logic [3:0] ham_data_t;
    typedef logic [HAM_CODE_W-1:0] ham_code_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ham_tx_state_e;
    function automatic ham_code_t ham_encode(input ham_data_t d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction
endpackage

// File: rtl/ham_tx_fifo.sv
// ham_tx_fifo: synchronous codeword FIFO with push/pop/full/empty/count.
module ham_tx_fifo
    import ham_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  ham_code_t                    i_data,
    input  logic                         i_pop,
    output ham_code_t                    o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    ham_code_t     r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wptr] <= i_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/ham_encoder_tx.sv
// ham_encoder_tx: Hamming(7,4) encoder, codeword FIFO and framed idle-high serializer.
// Defining HAM_TX_PARITY_EN appends an overall even-parity bit (SECDED) to each frame.
module ham_encoder_tx
    import ham_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        tx_serial,
    output logic                        tx_busy,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);
`ifdef HAM_TX_PARITY_EN
    localparam int NBITS = HAM_CODE_W + 1;
`else
    localparam int NBITS = HAM_CODE_W;
`endif
    localparam int BW = $clog2(BIT_CYCLES + 1);
    localparam int IW = $clog2(NBITS + 1);
    ham_tx_state_e    r_state;
    logic [BW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NBITS-1:0] r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    ham_code_t        w_head;
    logic [NBITS-1:0] w_frame;
    assign data_ready = !w_full;
    assign w_push     = data_valid && !w_full;
    assign w_bit_end  = r_cnt == BW'(BIT_CYCLES - 1);
    assign w_pop      = !w_empty && (r_state == IDLE || (r_state == STOP && w_bit_end));
`ifdef HAM_TX_PARITY_EN
    assign w_frame = {^w_head, w_head};
`else
    assign w_frame = w_head;
`endif
    ham_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (ham_encode(data_in)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );
    // A pop always starts a frame, whether from IDLE or back-to-back from STOP.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_pop) begin
            r_state <= START;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= w_frame;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else if (r_state != IDLE) begin
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end)
                case (r_state)
                    START: begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                    DATA: if (r_idx == IW'(NBITS - 1)) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
        end
    assign tx_serial = r_tx;
    assign tx_busy   = r_busy;
endmodule

// File: tb/tb_ham_encoder_tx.sv
// tb_ham_encoder_tx: directed bench with a line deserializer and a single-error-correcting decoder model.
module tb_ham_encoder_tx;
    localparam int BC    = 4;
    localparam int DEPTH = 4;
`ifdef HAM_TX_PARITY_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif
    localparam int FR = BC * (NB + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    logic [8:0] rx_q[$];
    logic [6:0] tbl [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                             7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
    logic [7:0] m_w;
    logic       m_ok;
    logic       m_stp;

    ham_encoder_tx #(.DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_rx(input logic [6:0] cw);
        return {1'b1, (NB == 8) ? ^cw : 1'b0, cw};
    endfunction

    function automatic logic [6:0] decode(input logic [6:0] c);
        logic [2:0] s;
        s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
        return (s == 3'd0) ? c : c ^ (7'b1 << (s - 3'd1));
    endfunction

    task automatic check_rx(input string tag, input logic [6:0] cw);
        logic [31:0] obs;
        obs = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hDEAD;
        check(tag, obs, 32'(exp_rx(cw)));
    endtask

    task automatic push(input logic [3:0] d);
        int n;
        n = 0;
        while (!data_ready && n < 4 * FR) begin
            tick;
            n++;
        end
        data_in = d;
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((tx_busy || fifo_count != 0) && n < 24 * FR) begin
            tick;
            n++;
        end
        check("drain_idle", {tx_busy, fifo_count}, 0);
    endtask

    // Deserializer: samples mid-bit on the falling edge; frames hit by reset are dropped.
    initial forever begin
        @(negedge clk);
        if (rst_n && tx_serial === 1'b0) begin
            m_ok = 1'b1;
            m_w = '0;
            m_stp = 1'b0;
            for (int k = 1; k <= BC * (NB + 1) + BC / 2; k++) begin
                @(negedge clk);
                if (!rst_n) m_ok = 1'b0;
                if (k >= BC && k % BC == BC / 2) begin
                    if (k / BC - 1 < NB) m_w[k/BC-1] = tx_serial;
                    else m_stp = tx_serial;
                end
            end
            if (m_ok) rx_q.push_back({m_stp, m_w});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int n, acc;
        logic [3:0] vals [6];
        logic [8:0] rx;
        vals = '{4'h3, 4'h9, 4'hE, 4'h6, 4'h1, 4'h1};
        repeat (2) tick;
        check("reset_tx", tx_serial, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ready", data_ready, 1);
        rst_n = 1'b1;
        tick;
        // single frame of 4'b1011
        data_in = 4'b1011;
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        check("t1_count", fifo_count, 1);
        check("t1_idle_before", tx_serial, 1);
        tick;
        check("t1_start", tx_serial, 0);
        check("t1_popped", fifo_count, 0);
        n = 0;
        acc = 0;
        for (int i = 0; i < FR + 8; i++) begin
            if (i < BC && tx_serial == 1'b0) acc++;
            if (i == BC) check("t1_first_bit", tx_serial, 1);
            if (tx_busy) n++;
            tick;
        end
        check("t1_start_len", acc, BC);
        check("t1_busy_len", n, FR);
        check("t1_line_idle", tx_serial, 1);
        check_rx("t1_frame", tbl[11]);
        // back-to-back 0 then F
        data_in = 4'h0;
        data_valid = 1'b1;
        tick;
        data_in = 4'hF;
        tick;
        data_valid = 1'b0;
        n = 0;
        acc = 0;
        for (int i = 0; i < 2 * FR + 8; i++) begin
            n = tx_busy ? n + 1 : 0;
            if (n > acc) acc = n;
            tick;
        end
        check("t2_busy_run", acc, 2 * FR);
        check_rx("t2_frame0", tbl[0]);
        check_rx("t2_frameF", tbl[15]);
        // fill while busy
        data_in = 4'h5;
        data_valid = 1'b1;
        tick;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            data_in = vals[acc];
            if (data_ready) acc++;
            tick;
        end
        check("t3_accepts", acc, DEPTH);
        check("t3_full_count", fifo_count, DEPTH);
        check("t3_not_ready", data_ready, 0);
        n = 0;
        while (!data_ready && n < 2 * FR) begin
            tick;
            n++;
        end
        data_valid = 1'b0;
        check("t3_ready_back", data_ready, 1);
        check("t3_count_after_pop", fifo_count, 3);
        check("t3_pop_start", tx_serial, 0);
        // push on the same edge as a STOP->START pop
        repeat (FR) tick;
        check("t4_pre_count", fifo_count, 2);
        repeat (FR - 1) tick;
        data_in = 4'hC;
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        check("t4_same_edge_count", fifo_count, 2);
        check("t4_same_edge_start", tx_serial, 0);
        drain;
        check_rx("t3_frame5", tbl[5]);
        for (int i = 0; i < 4; i++) check_rx("t3_order", tbl[vals[i]]);
        check_rx("t4_frameC", tbl[12]);
        // reset mid-DATA
        data_in = 4'hA;
        data_valid = 1'b1;
        tick;
        data_in = 4'h7;
        tick;
        data_in = 4'h2;
        tick;
        data_valid = 1'b0;
        repeat (16) tick;
        check("t5_pre_busy", tx_busy, 1);
        check("t5_pre_count", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx_serial, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_ready", data_ready, 1);
        tick;
        tick;
        rst_n = 1'b1;
        n = 0;
        repeat (3 * FR) begin
            if (tx_serial == 1'b0 || tx_busy) n++;
            tick;
        end
        check("t5_no_residual", n, 0);
        check("t5_rx_empty", rx_q.size(), 0);
        // loopback through decoder model with single-bit flips
        for (int d = 0; d < 16; d++) push(4'(d));
        drain;
        for (int d = 0; d < 16; d++) begin
            rx = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h0;
            check("lb_frame", rx, exp_rx(tbl[d]));
            check("lb_clean", decode(rx[6:0]), tbl[d]);
            for (int p = 0; p < 7; p++)
                check("lb_correct", decode(rx[6:0] ^ (7'b1 << p)), tbl[d]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
